// File: rtl/riscv_test_monitor_pkg.sv
// -----------------------------------------------------------------------------
// riscv_test_monitor_pkg
//   Shared definitions for the riscv-tests pass/fail monitor:
//   - FSM state encoding (also exported on the monitor's debug state port)
//   - default riscv-tests convention register indices
//   - datapath widths shared with the register file and core
// -----------------------------------------------------------------------------
package riscv_test_monitor_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   // riscv-tests convention: x3 = test number, x26 = done, x27 = pass
   localparam logic [REG_ADDR_W-1:0] DEF_TNUM_REG = 5'd3;
   localparam logic [REG_ADDR_W-1:0] DEF_DONE_REG = 5'd26;
   localparam logic [REG_ADDR_W-1:0] DEF_PASS_REG = 5'd27;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_PASS    = 3'd3,
      ST_FAIL    = 3'd4,
      ST_TIMEOUT = 3'd5
   } state_t;

   // Terminal states are absorbing until reset.
   function automatic logic is_terminal(input state_t s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
   endfunction

   // States in which the cycle counter runs and timeout is watched.
   function automatic logic is_active(input state_t s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/riscv_test_monitor.sv
// -----------------------------------------------------------------------------
// riscv_test_monitor
//   Pass/fail monitor snooping the core's register-file writeback port.
//   It shadows the test-number and pass-flag registers, waits for a write of 1
//   to the done register, lets the pipeline drain for DRAIN_CYCLES, then judges
//   PASS/FAIL from the shadowed pass flag. A watchdog declares TIMEOUT after
//   TIMEOUT_CYCLES cycles of RUN+DRAIN. All result outputs are sticky until rst.
//
// Parameters:
//   DRAIN_CYCLES   (1..255) cycles between the done write and the judgement
//   TIMEOUT_CYCLES (>= 2)   RUN+DRAIN cycles before timeout
//   TNUM_REG / DONE_REG / PASS_REG  register indices (non-zero)
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   enable_i        arms the monitor (IDLE -> RUN)
//   wb_we_i         register-file write enable
//   wb_waddr_i      register-file write address
//   wb_wdata_i      register-file write data
//   done_o          sticky: judgement made (pass, fail or timeout)
//   pass_o          sticky: test passed
//   fail_o          sticky: test failed or timed out
//   timeout_o       sticky: timeout reached
//   fail_testnum_o  test number frozen at judgement, 0 on pass
//   cycle_cnt_o     cycles spent in RUN+DRAIN, saturating
//   state_o         current FSM state (debug)
//
// Handshake: there is none; the writeback port is a one-cycle strobe
// (wb_we_i qualifies wb_waddr_i/wb_wdata_i on the edge it is sampled) and the
// monitor never back-pressures the core.
// -----------------------------------------------------------------------------
module riscv_test_monitor
   import riscv_test_monitor_pkg::*;
#(
   parameter int                    DRAIN_CYCLES   = 10,
   parameter int                    TIMEOUT_CYCLES = 100000,
   parameter logic [REG_ADDR_W-1:0] TNUM_REG       = DEF_TNUM_REG,
   parameter logic [REG_ADDR_W-1:0] DONE_REG       = DEF_DONE_REG,
   parameter logic [REG_ADDR_W-1:0] PASS_REG       = DEF_PASS_REG
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_waddr_i,
   input  logic [XLEN-1:0]       wb_wdata_i,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  fail_o,
   output logic                  timeout_o,
   output logic [XLEN-1:0]       fail_testnum_o,
   output logic [XLEN-1:0]       cycle_cnt_o,
   output logic [2:0]            state_o
);

   localparam logic [7:0]      DRAIN_LOAD   = 8'(DRAIN_CYCLES - 1);
   localparam logic [XLEN-1:0] TIMEOUT_LAST = XLEN'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   state_t          w_next;

   logic [XLEN-1:0] r_tnum;
   logic [XLEN-1:0] r_pass_flag;
   logic [7:0]      r_drain_cnt;
   logic [XLEN-1:0] r_cycle_cnt;

   logic            r_done;
   logic            r_pass;
   logic            r_fail;
   logic            r_timeout;
   logic [XLEN-1:0] r_fail_testnum;

   logic            w_wr_valid;
   logic            w_done_trig;
   logic            w_timeout_hit;
   logic            w_drain_zero;
   logic            w_enter_term;

   // Writes to x0 never reach any shadow.
   assign w_wr_valid    = wb_we_i && (wb_waddr_i != '0);
   // The done trigger is decoded straight from the write port; only the exact
   // value 1 counts, other values written to the done register are ignored.
   assign w_done_trig   = w_wr_valid && (wb_waddr_i == DONE_REG) &&
                          (wb_wdata_i == XLEN'(1));
   assign w_timeout_hit = (r_cycle_cnt == TIMEOUT_LAST);
   assign w_drain_zero  = (r_drain_cnt == 8'd0);
   assign w_enter_term  = is_terminal(w_next) && !is_terminal(r_state);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable_i) w_next = ST_RUN;
         end
         ST_RUN: begin
            // Done trigger takes priority over a coincident timeout.
            if (w_done_trig)        w_next = ST_DRAIN;
            else if (w_timeout_hit) w_next = ST_TIMEOUT;
         end
         ST_DRAIN: begin
            // Judgement uses the shadow as held before this edge; a write
            // landing on the same edge is shadowed but not considered.
            if (w_drain_zero)       w_next = (r_pass_flag == XLEN'(1)) ? ST_PASS : ST_FAIL;
            else if (w_timeout_hit) w_next = ST_TIMEOUT;
         end
         ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            w_next = r_state;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- shadows
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tnum      <= '0;
         r_pass_flag <= '0;
      end else if (w_wr_valid) begin
         if (wb_waddr_i == TNUM_REG) r_tnum      <= wb_wdata_i;
         if (wb_waddr_i == PASS_REG) r_pass_flag <= wb_wdata_i;
      end
   end

   // ---------------------------------------------------------------- counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drain_cnt <= '0;
         r_cycle_cnt <= '0;
      end else begin
         if ((r_state == ST_RUN) && (w_next == ST_DRAIN))
            r_drain_cnt <= DRAIN_LOAD;
         else if ((r_state == ST_DRAIN) && !w_drain_zero)
            r_drain_cnt <= r_drain_cnt - 8'd1;

         // Counts edges spent remaining in RUN/DRAIN; the edge that enters a
         // terminal state leaves the count frozen. Saturates at all-ones.
         if (is_active(r_state) && is_active(w_next) && (r_cycle_cnt != '1))
            r_cycle_cnt <= r_cycle_cnt + XLEN'(1);
      end
   end

   // ---------------------------------------------------------------- results
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done         <= 1'b0;
         r_pass         <= 1'b0;
         r_fail         <= 1'b0;
         r_timeout      <= 1'b0;
         r_fail_testnum <= '0;
      end else if (w_enter_term) begin
         r_done <= 1'b1;
         case (w_next)
            ST_PASS: begin
               r_pass         <= 1'b1;
               r_fail_testnum <= '0;
            end
            ST_FAIL: begin
               r_fail         <= 1'b1;
               r_fail_testnum <= r_tnum;
            end
            default: begin
               r_fail         <= 1'b1;
               r_timeout      <= 1'b1;
               r_fail_testnum <= r_tnum;
            end
         endcase
      end
   end

   assign done_o         = r_done;
   assign pass_o         = r_pass;
   assign fail_o         = r_fail;
   assign timeout_o      = r_timeout;
   assign fail_testnum_o = r_fail_testnum;
   assign cycle_cnt_o    = r_cycle_cnt;
   assign state_o        = r_state;

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

   logic        clk;
   logic        rst;
   logic        enable_i;
   logic        wb_we_i;
   logic [4:0]  wb_waddr_i;
   logic [31:0] wb_wdata_i;
   logic        done_o;
   logic        pass_o;
   logic        fail_o;
   logic        timeout_o;
   logic [31:0] fail_testnum_o;
   logic [31:0] cycle_cnt_o;
   logic [2:0]  state_o;

   int n_vec;
   int n_err;

   riscv_test_monitor #(
      .DRAIN_CYCLES   (10),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable_i       (enable_i),
      .wb_we_i        (wb_we_i),
      .wb_waddr_i     (wb_waddr_i),
      .wb_wdata_i     (wb_wdata_i),
      .done_o         (done_o),
      .pass_o         (pass_o),
      .fail_o         (fail_o),
      .timeout_o      (timeout_o),
      .fail_testnum_o (fail_testnum_o),
      .cycle_cnt_o    (cycle_cnt_o),
      .state_o        (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one rising edge, then settle 1 time unit so checks sit away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      enable_i = 1'b0;
      wb_we_i  = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
   endtask

   // single register-file write applied on the next edge
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wb_we_i    = 1'b1;
      wb_waddr_i = a;
      wb_wdata_i = d;
      tick();
      wb_we_i    = 1'b0;
      wb_waddr_i = 5'd0;
      wb_wdata_i = 32'd0;
   endtask

   task automatic arm();
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic d, input logic p,
                            input logic f, input logic t);
      chk({tag, ".done"},    32'(done_o),    32'(d));
      chk({tag, ".pass"},    32'(pass_o),    32'(p));
      chk({tag, ".fail"},    32'(fail_o),    32'(f));
      chk({tag, ".timeout"}, 32'(timeout_o), 32'(t));
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b0;
      enable_i   = 1'b0;
      wb_we_i    = 1'b0;
      wb_waddr_i = 5'd0;
      wb_wdata_i = 32'd0;

      // ---- reset state
      do_reset();
      chk("rst.state", 32'(state_o), 32'd0);
      chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.tnum", fail_testnum_o, 32'd0);
      chk("rst.cnt", cycle_cnt_o, 32'd0);

      // ---- pass: x3=5, x27=1, x26=1 at edge t; judged at edge t+10
      arm();
      chk("pass.run", 32'(state_o), 32'd1);
      chk("pass.cnt0", cycle_cnt_o, 32'd0);
      wr(5'd3, 32'd5);
      chk("pass.cnt1", cycle_cnt_o, 32'd1);
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      chk("pass.drain", 32'(state_o), 32'd2);
      ticks(9);
      chk("pass.t9.done", 32'(done_o), 32'd0);
      chk("pass.t9.state", 32'(state_o), 32'd2);
      tick();
      chk_flags("pass", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("pass.tnum", fail_testnum_o, 32'd0);
      chk("pass.state", 32'(state_o), 32'd3);
      // absorbing: enable and further writes have no effect
      enable_i = 1'b1;
      wr(5'd27, 32'd0);
      wr(5'd26, 32'd1);
      ticks(12);
      enable_i = 1'b0;
      chk("pass.hold.state", 32'(state_o), 32'd3);
      chk_flags("pass.hold", 1'b1, 1'b1, 1'b0, 1'b0);

      // ---- fail: x3=7, x27=0, x26=1
      do_reset();
      arm();
      wr(5'd3, 32'd7);
      wr(5'd27, 32'd0);
      wr(5'd26, 32'd1);
      ticks(10);
      chk_flags("fail", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("fail.tnum", fail_testnum_o, 32'd7);
      chk("fail.state", 32'(state_o), 32'd4);

      // ---- late write on the 5th DRAIN edge -> pass
      do_reset();
      arm();
      wr(5'd27, 32'd0);
      wr(5'd26, 32'd1);
      ticks(4);
      wr(5'd27, 32'd1);
      ticks(5);
      chk("late5.state", 32'(state_o), 32'd3);
      chk("late5.pass", 32'(pass_o), 32'd1);

      // ---- late write on the judging edge -> fail with old shadow
      do_reset();
      arm();
      wr(5'd3, 32'd9);
      wr(5'd27, 32'd0);
      wr(5'd26, 32'd1);
      ticks(9);
      wr(5'd27, 32'd1);
      chk("late10.state", 32'(state_o), 32'd4);
      chk("late10.fail", 32'(fail_o), 32'd1);
      chk("late10.tnum", fail_testnum_o, 32'd9);

      // ---- timeout after 50 RUN edges
      do_reset();
      arm();
      ticks(49);
      chk("to.pre.state", 32'(state_o), 32'd1);
      chk("to.pre.cnt", cycle_cnt_o, 32'd49);
      chk("to.pre.done", 32'(done_o), 32'd0);
      tick();
      chk("to.state", 32'(state_o), 32'd5);
      chk_flags("to", 1'b1, 1'b0, 1'b1, 1'b1);
      chk("to.cnt", cycle_cnt_o, 32'd49);
      chk("to.tnum", fail_testnum_o, 32'd0);
      ticks(3);
      chk("to.frozen", cycle_cnt_o, 32'd49);

      // ---- done write on the timeout edge: DRAIN wins
      do_reset();
      arm();
      wr(5'd3, 32'd4);
      wr(5'd27, 32'd1);
      ticks(47);
      chk("race.pre.cnt", cycle_cnt_o, 32'd49);
      wr(5'd26, 32'd1);
      chk("race.state", 32'(state_o), 32'd2);
      chk("race.timeout", 32'(timeout_o), 32'd0);
      ticks(10);
      chk("race.end", 32'(state_o), 32'd3);
      chk_flags("race", 1'b1, 1'b1, 1'b0, 1'b0);

      // ---- filters: done in IDLE, x0 write, done value 2
      do_reset();
      wr(5'd26, 32'd1);
      tick();
      chk("flt.idle", 32'(state_o), 32'd0);
      wr(5'd3, 32'd11);
      wr(5'd0, 32'd55);
      arm();
      wr(5'd27, 32'd0);
      wr(5'd26, 32'd2);
      ticks(12);
      chk("flt.val2.state", 32'(state_o), 32'd1);
      chk("flt.val2.done", 32'(done_o), 32'd0);
      wr(5'd26, 32'd1);
      ticks(10);
      chk("flt.state", 32'(state_o), 32'd4);
      chk("flt.tnum", fail_testnum_o, 32'd11);

      // ---- reset in the middle of DRAIN, then a clean pass
      do_reset();
      arm();
      wr(5'd3, 32'd2);
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      ticks(3);
      chk("mid.drain", 32'(state_o), 32'd2);
      do_reset();
      chk("mid.rst.state", 32'(state_o), 32'd0);
      chk_flags("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid.rst.cnt", cycle_cnt_o, 32'd0);
      ticks(15);
      chk("mid.idle.done", 32'(done_o), 32'd0);
      arm();
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      ticks(10);
      chk_flags("mid.pass", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mid.tnum", fail_testnum_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
